// File: rtl/uart_rx_frame_controller_if.sv
// Consumer-side bundle of the UART receive controller: serial line, handshake, payload and status.
// oErrCount exists only when UART_RX_ERR_COUNT_EN is defined.
interface uart_rx_frame_controller_if #(
    parameter int DATA_BITS = 8
);
    logic                 iRx;
    logic                 iReady;
    logic [DATA_BITS-1:0] oData;
    logic                 oValid;
    logic                 oParityError;
    logic                 oFramingError;
    logic                 oOverrun;
    logic                 oBusy;
`ifdef UART_RX_ERR_COUNT_EN
    logic [7:0]           oErrCount;
`endif

    modport slave (
        input  iRx, iReady,
`ifdef UART_RX_ERR_COUNT_EN
        output oErrCount,
`endif
        output oData, oValid, oParityError, oFramingError, oOverrun, oBusy
    );

    modport master (
        output iRx, iReady,
`ifdef UART_RX_ERR_COUNT_EN
        input  oErrCount,
`endif
        input  oData, oValid, oParityError, oFramingError, oOverrun, oBusy
    );
endinterface

// File: rtl/uart_rx_frame_controller.sv
// Oversampling UART receiver (start, DATA_BITS LSB first, even parity, stop) with valid/ready output.
// Optional macro UART_RX_ERR_COUNT_EN adds an 8-bit saturating count of errored frames.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | confirming the start bit at mid-bit
// DATA   | sampling payload bits, LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit
// LOAD   | parity check enabled, output registers load

module EvenParityCheck #(
    parameter int WORD_LENGTH = 10
) (
    input  logic                   iEnable,
    input  logic [WORD_LENGTH-1:0] iWord,
    output logic                   oParityError
);
    // MSB carries the stop bit, which is not covered by parity
    logic unused_stop;
    assign unused_stop  = iWord[WORD_LENGTH-1];
    assign oParityError = iEnable & (^iWord[WORD_LENGTH-2:0]);
endmodule

module uart_rx_frame_controller #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                         iClk,
    input  logic                         iReset,
    uart_rx_frame_controller_if.slave    bus
);
    localparam int TICK_W  = $clog2(CLKS_PER_BIT);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);
    localparam int FRAME_W = DATA_BITS + 2;
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_LOAD} state_t;

    state_t               state_q, state_d;
    logic                 sync_q, rx_s_q, rx_last_q;
    logic [TICK_W-1:0]    tick_q, tick_d, tick_adv;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 chk_en, parity_err;

    EvenParityCheck #(.WORD_LENGTH(FRAME_W)) u_parity (
        .iEnable      (chk_en),
        .iWord        (frame_q),
        .oParityError (parity_err)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_last_q <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= bus.iRx;
            rx_s_q    <= sync_q;
            rx_last_q <= rx_s_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign tick_adv = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        chk_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_last_q && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                tick_d = tick_adv;
                if (tick_q == TICK_HALF) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                tick_d = tick_adv;
                if (tick_q == TICK_LAST) begin
                    // shifting right leaves bit 0 of the payload in frame[1] after the last sample
                    frame_d[DATA_BITS:1] = {rx_s_q, frame_q[DATA_BITS:2]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                tick_d = tick_adv;
                if (tick_q == TICK_LAST) begin
                    frame_d[0] = rx_s_q;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                tick_d = tick_adv;
                if (tick_q == TICK_LAST) begin
                    frame_d[DATA_BITS+1] = rx_s_q;
                    state_d              = S_LOAD;
                end
            end
            S_LOAD: begin
                chk_en  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (chk_en) begin
            data_d  = frame_q[DATA_BITS:1];
            perr_d  = parity_err;
            ferr_d  = ~frame_q[DATA_BITS+1];
            valid_d = 1'b1;
            ovr_d   = valid_q & ~bus.iReady;
        end else if (valid_q && bus.iReady) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

`ifdef UART_RX_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (chk_en && (parity_err || !frame_q[DATA_BITS+1]) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge iClk) begin
        if (iReset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.oErrCount = err_cnt_q;
`endif

    assign bus.oData         = data_q;
    assign bus.oValid        = valid_q;
    assign bus.oParityError  = perr_q;
    assign bus.oFramingError = ferr_q;
    assign bus.oOverrun      = ovr_q;
    assign bus.oBusy         = (state_q != S_IDLE);
endmodule
